// File: rtl/exc_sequencer.sv
// Book-E exception/interrupt sequencer: arbitrates exception sources, saves state over the
// shared SPR write port, vectors through IVPR/IVORn and sequences rfi returns.
// Optional macro EXC_FLUSH_TIMEOUT_EN adds a bounded FLUSH wait with a sticky flush_timeout flag.
module exc_sequencer #(
    parameter logic [0:31] MSR_KEEP_MASK = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_err,
    input  logic [2:0]  prog_err_code,
    output logic        prog_ack,
    input  logic        sc_req,
    output logic        sc_ack,
    input  logic        dsi_req,
    output logic        dsi_ack,
    input  logic        dsi_is_store,
    input  logic        isi_req,
    output logic        isi_ack,
    input  logic        ext_irq,
    input  logic        rfi_req,
    output logic        rfi_ack,
    input  logic [0:31] exc_pc,
    input  logic [0:31] exc_dear,
    input  logic [0:31] MSR,
    input  logic        pipe_empty,
    output logic        flush,
    output logic [9:0]  spr_rsprn,
    input  logic [0:31] spr_rdata,
    output logic        spr_we,
    output logic [9:0]  spr_wsprn,
    output logic [0:31] spr_wdata,
    output logic        msr_we,
    output logic [0:31] msr_wdata,
    output logic        redirect,
    output logic [0:31] redirect_pc,
`ifdef EXC_FLUSH_TIMEOUT_EN
    output logic        flush_timeout,
`endif
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, FLUSH, W_SRR0, W_SRR1, W_ESR, W_DEAR, RD_IVPR, RD_IVOR,
        VECTOR, RD_SRR0, RD_SRR1, RETURN
    } state_t;

    typedef enum logic [2:0] {
        SRC_ISI, SRC_DSI, SRC_PROG, SRC_SC, SRC_EXT, SRC_RFI
    } src_t;

    localparam logic [9:0] SPRN_SRR0 = 10'd26;
    localparam logic [9:0] SPRN_SRR1 = 10'd27;
    localparam logic [9:0] SPRN_DEAR = 10'd61;
    localparam logic [9:0] SPRN_ESR  = 10'd62;
    localparam logic [9:0] SPRN_IVPR = 10'd63;

    state_t      stateReg, stateNext;
    src_t        srcReg, reqSrc;
    logic        reqValid;
    logic [2:0]  codeReg;
    logic        storeReg;
    logic [0:31] pcReg, dearReg, msrReg;
    logic [0:31] dataAReg, dataBReg;   // IVPR/IVOR on entry, SRR0/SRR1 on rfi
    logic [9:0]  ivorSprn;
    logic [0:31] esrVal;
    logic        timeoutHit;

    // Fixed priority; external input qualified by the live MSR[EE]
    always_comb begin
        reqValid = 1'b1;
        reqSrc   = SRC_ISI;
        if (isi_req)                 reqSrc = SRC_ISI;
        else if (dsi_req)            reqSrc = SRC_DSI;
        else if (prog_err)           reqSrc = SRC_PROG;
        else if (sc_req)             reqSrc = SRC_SC;
        else if (ext_irq && MSR[16]) reqSrc = SRC_EXT;
        else if (rfi_req)            reqSrc = SRC_RFI;
        else                         reqValid = 1'b0;
    end

`ifdef EXC_FLUSH_TIMEOUT_EN
    logic [5:0] flushCntReg;
    assign timeoutHit = (flushCntReg == 6'd62);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flushCntReg   <= '0;
            flush_timeout <= 1'b0;
        end else if (stateReg == FLUSH && !pipe_empty) begin
            flushCntReg <= flushCntReg + 6'd1;
            if (timeoutHit) flush_timeout <= 1'b1;
        end else begin
            flushCntReg <= '0;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
            srcReg   <= SRC_ISI;
            codeReg  <= '0;
            storeReg <= 1'b0;
            pcReg    <= '0;
            dearReg  <= '0;
            msrReg   <= '0;
            dataAReg <= '0;
            dataBReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == IDLE && reqValid) begin
                srcReg   <= reqSrc;
                codeReg  <= prog_err_code;
                storeReg <= dsi_is_store;
                pcReg    <= exc_pc;
                dearReg  <= exc_dear;
                msrReg   <= MSR;
            end
            if (stateReg == RD_IVPR || stateReg == RD_SRR0) dataAReg <= spr_rdata;
            if (stateReg == RD_IVOR || stateReg == RD_SRR1) dataBReg <= spr_rdata;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (reqValid) stateNext = FLUSH;
            FLUSH:   if (pipe_empty || timeoutHit)
                         stateNext = (srcReg == SRC_RFI) ? RD_SRR0 : W_SRR0;
            W_SRR0:  stateNext = W_SRR1;
            W_SRR1:  stateNext = (srcReg == SRC_PROG || srcReg == SRC_DSI) ? W_ESR : RD_IVPR;
            W_ESR:   stateNext = (srcReg == SRC_DSI) ? W_DEAR : RD_IVPR;
            W_DEAR:  stateNext = RD_IVPR;
            RD_IVPR: stateNext = RD_IVOR;
            RD_IVOR: stateNext = VECTOR;
            VECTOR:  stateNext = IDLE;
            RD_SRR0: stateNext = RD_SRR1;
            RD_SRR1: stateNext = RETURN;
            RETURN:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        case (srcReg)
            SRC_ISI:  ivorSprn = 10'd403;
            SRC_DSI:  ivorSprn = 10'd402;
            SRC_PROG: ivorSprn = 10'd406;
            SRC_SC:   ivorSprn = 10'd408;
            default:  ivorSprn = 10'd404;
        endcase
        esrVal = '0;
        if (srcReg == SRC_PROG) begin
            esrVal[4] = codeReg[2];
            esrVal[5] = codeReg[1];
            esrVal[6] = codeReg[0];
        end
        if (srcReg == SRC_DSI) esrVal[8] = storeReg;
    end

    always_comb begin
        busy        = (stateReg != IDLE);
        flush       = (stateReg != IDLE);
        spr_rsprn   = '0;
        spr_we      = 1'b0;
        spr_wsprn   = '0;
        spr_wdata   = '0;
        msr_we      = 1'b0;
        msr_wdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        prog_ack    = 1'b0;
        sc_ack      = 1'b0;
        dsi_ack     = 1'b0;
        isi_ack     = 1'b0;
        rfi_ack     = 1'b0;
        case (stateReg)
            W_SRR0:  begin spr_we = 1'b1; spr_wsprn = SPRN_SRR0; spr_wdata = pcReg;   end
            W_SRR1:  begin spr_we = 1'b1; spr_wsprn = SPRN_SRR1; spr_wdata = msrReg;  end
            W_ESR:   begin spr_we = 1'b1; spr_wsprn = SPRN_ESR;  spr_wdata = esrVal;  end
            W_DEAR:  begin spr_we = 1'b1; spr_wsprn = SPRN_DEAR; spr_wdata = dearReg; end
            RD_IVPR: spr_rsprn = SPRN_IVPR;
            RD_IVOR: spr_rsprn = ivorSprn;
            RD_SRR0: spr_rsprn = SPRN_SRR0;
            RD_SRR1: spr_rsprn = SPRN_SRR1;
            VECTOR: begin
                redirect    = 1'b1;
                redirect_pc = {dataAReg[0:15], dataBReg[16:27], 4'b0000};
                msr_we      = 1'b1;
                msr_wdata   = msrReg & MSR_KEEP_MASK;
                isi_ack     = (srcReg == SRC_ISI);
                dsi_ack     = (srcReg == SRC_DSI);
                prog_ack    = (srcReg == SRC_PROG);
                sc_ack      = (srcReg == SRC_SC);
            end
            RETURN: begin
                redirect    = 1'b1;
                redirect_pc = dataAReg;
                msr_we      = 1'b1;
                msr_wdata   = dataBReg;
                rfi_ack     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Interrupt/exception sequencer for the core's Book-E style exception path.
- Arbitrates pending exception sources: programError output, system call, data/instruction storage, external input, and rfi.
- Flushes the pipe and saves state to SRR0/SRR1/ESR/DEAR over the shared SPR write port.
- Fetches IVPR/IVORn, updates MSR, redirects fetch, then acks the source; also sequences rfi returns.

Parameters:
- MSR_KEEP_MASK, 32'h0000_1000 ([0:31] order, ME kept): MSR bits preserved on exception entry; all other bits cleared.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- prog_err  in  1  program error pending; sticky until prog_ack
- prog_err_code  in  3  {illegal, privilege, trap}
- prog_ack  out  1  one-cycle ack
- sc_req / sc_ack  in / out  1 / 1  system call
- dsi_req / dsi_ack  in / out  1 / 1  data storage
- dsi_is_store  in  1  faulting access was a store
- isi_req / isi_ack  in / out  1 / 1  instruction storage
- ext_irq  in  1  level external input, masked by MSR[EE]
- rfi_req / rfi_ack  in / out  1 / 1  return from interrupt
- exc_pc  in  [0:31]  SRR0 value (faulting PC; next PC for sc)
- exc_dear  in  [0:31]  faulting data address
- MSR  in  [0:31]  current MSR
- pipe_empty  in  1  pipeline drained
- flush  out  1  kill/hold pipeline
- spr_rsprn  out  10  SPR read select
- spr_rdata  in  [0:31]  combinational read data
- spr_we, spr_wsprn, spr_wdata  out  1, 10, [0:31]  SPR write port
- msr_we, msr_wdata  out  1, [0:31]  MSR write
- redirect, redirect_pc  out  1, [0:31]  fetch redirect
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE and all outputs are 0.
  - Capture registers clear.
  - Reset mid-sequence abandons the sequence; partial SPR writes are not undone.
- Arbitration in IDLE, fixed priority: isi > dsi > prog_err > sc > (ext_irq & MSR[EE]) > rfi.
- On accepting a source, capture in one cycle: source id, prog_err_code, dsi_is_store, exc_pc, exc_dear, MSR.
- Requests are ignored while busy. Requesters hold their request until acked.
- States:
  - IDLE: wait for a request.
  - FLUSH: flush=1; stay while pipe_empty=0.
  - W_SRR0: write SRR0 = captured exc_pc.
  - W_SRR1: write SRR1 = captured MSR.
  - W_ESR (prog, dsi only): ESR = 0 except:
    - prog: bit4 PIL = illegal, bit5 PPR = privilege, bit6 PTR = trap.
    - dsi: bit8 ST = dsi_is_store.
  - W_DEAR (dsi only): write DEAR = captured exc_dear.
  - RD_IVPR: spr_rsprn = IVPR; latch spr_rdata.
  - RD_IVOR: spr_rsprn = IVORn; latch spr_rdata. Vector map: isi→3, dsi→2, prog→6, sc→8, ext→4.
  - VECTOR (single cycle):
    - redirect=1, redirect_pc = {IVPR[0:15], IVOR[16:27], 4'b0}.
    - msr_we=1, msr_wdata = captured MSR & MSR_KEEP_MASK.
    - The source's ack pulses. ext_irq has no ack.
    - Next state IDLE.
  - rfi path: FLUSH → RD_SRR0 → RD_SRR1 → RETURN. RETURN does redirect to SRR0, msr_we with SRR1, rfi_ack; then IDLE.
- flush stays 1 from FLUSH through VECTOR/RETURN inclusive. busy=1 in every non-IDLE state.
- spr_we is 1 only in W_* states, with exactly one SPR written per cycle.
- Latency, counted from the IDLE sampling edge with pipe_empty=1, to the ack cycle:
  - prog: 7
  - sc, isi, ext: 6
  - dsi: 8
  - rfi: 4
- Every wait cycle in FLUSH adds one cycle to these figures.
- Simultaneous requests: the highest-priority source is served. Lower-priority requests remain pending and are re-arbitrated in the next IDLE.
- ext_irq is masked by MSR[EE] as sampled in IDLE. If it deasserts after capture, the sequence still completes.

Optional Feature:
- Macro EXC_FLUSH_TIMEOUT_EN.
- With it:
  - A 6-bit counter runs in FLUSH.
  - After 63 cycles with pipe_empty=0 the FSM proceeds anyway.
  - Sticky output flush_timeout (1 bit) is set; cleared only by rst.
- Without it: FLUSH waits indefinitely and the flush_timeout port does not exist.

Test Plan:
- prog_err=1, code=3'b010, exc_pc=32'h0000_1040, MSR=32'h0000_4000 (PR), IVPR=32'hFFFF_0000, IVOR6=32'h0000_0700, pipe_empty=1 → SRR0=0x1040, SRR1=0x4000, ESR=0x0400_0000, redirect_pc=0xFFFF_0700, msr_wdata=0, prog_ack pulses at cycle 7.
- dsi_req and sc_req together, dsi_is_store=1, exc_dear=0x0000_2004 → dsi served first (DEAR=0x2004, ESR=0x0080_0000, dsi_ack at cycle 8), then sc served, sc_ack 6 cycles after re-entering IDLE.
- ext_irq=1 with MSR[EE]=0 → busy stays 0 for 20 cycles; set MSR[EE]=1 → vector to IVPR|IVOR4 at cycle 6, no ack.
- rfi_req with SRR0=0x0000_3000, SRR1=0x0000_8000 → redirect_pc=0x3000, msr_wdata=0x8000, rfi_ack at cycle 4.
- pipe_empty held 0 for 5 cycles in FLUSH → prog_ack at cycle 12. Then assert rst=0 during W_SRR1 of a new sequence → all outputs 0 immediately, FSM back in IDLE.
- EXC_FLUSH_TIMEOUT_EN defined, pipe_empty stuck 0 → FSM leaves FLUSH after 63 cycles, flush_timeout=1.
